// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_e;

  localparam logic [6:0] SEG_DARK = 7'b0000000;

  function automatic logic [6:0] seg7_decode(input logic [3:0] hex);
    logic [6:0] seg;
    seg = SEG_DARK;
    case (hex)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan sequencer: BLANK/SHOW phase counter and digit index, frozen while ena=0.
// Exposes next-state values so the caller can register outputs on the same edge.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  output scan_state_e   state_nxt,
  output logic [IW-1:0] idx_nxt,
  output logic          phase_done,
  output logic          commit_stb
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // With no blanking gap, SHOW chains straight into the next digit's SHOW.
  localparam scan_state_e AFTER_SHOW = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  scan_state_e   state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    phase_done = 1'b0;
    commit_stb = 1'b0;
    if (ena) begin
      phase_done = (cnt == ((state == SHOW) ? DWELL_LAST : BLANK_LAST));
      if (!phase_done) begin
        cnt_nxt = cnt + 1'b1;
      end else begin
        cnt_nxt = '0;
        if (state == BLANK) begin
          state_nxt = SHOW;
        end else begin
          state_nxt = AFTER_SHOW;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      // Last cycle before SHOW(0) is entered: the frame boundary.
      commit_stb = phase_done && (state_nxt == SHOW) && (idx_nxt == '0);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit 7-seg driver; new words take effect at the next frame boundary.
// One-deep staging register: in_ready stays low from accept until the frame commit.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_digits,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e   state_nxt;
  logic [IW-1:0] idx_nxt;
  logic          phase_done, commit_stb;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .state_nxt (state_nxt),
    .idx_nxt   (idx_nxt),
    .phase_done(phase_done),
    .commit_stb(commit_stb)
  );

  logic                    stg_full;
  logic [4*NUM_DIGITS-1:0] stg_dig, disp_dig, disp_dig_nxt;
  logic [NUM_DIGITS-1:0]   stg_dp, disp_dp, disp_dp_nxt;
  logic                    accept, commit;

  assign in_ready = !stg_full;
  assign accept   = in_valid && !stg_full;
  assign commit   = commit_stb && stg_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_full <= 1'b0;
      stg_dig  <= '0;
      stg_dp   <= '0;
      disp_dig <= '0;
      disp_dp  <= '0;
    end else begin
      if (commit) begin
        stg_full <= 1'b0;
        disp_dig <= stg_dig;
        disp_dp  <= stg_dp;
      end else if (accept) begin
        stg_full <= 1'b1;
        stg_dig  <= in_digits;
        stg_dp   <= in_dp;
      end
    end
  end

  // Outputs load on the commit edge too, so decode from the post-commit word.
  assign disp_dig_nxt = commit ? stg_dig : disp_dig;
  assign disp_dp_nxt  = commit ? stg_dp  : disp_dp;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  nz_above;

  always_comb begin
    lz_blank = '0;
    nz_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_above    = nz_above || (disp_dig_nxt[4*i +: 4] != 4'h0);
      lz_blank[i] = (LZ_BLANK != 0) && !nz_above;
    end
  end

  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  always_comb begin
    sel_nxt = '0;
    seg_nxt = SEG_DARK;
    dp_nxt  = 1'b0;
    if (ena && (state_nxt == SHOW)) begin
      sel_nxt[idx_nxt] = 1'b1;
      seg_nxt = lz_blank[idx_nxt] ? SEG_DARK : seg7_decode(disp_dig_nxt[4*idx_nxt +: 4]);
      dp_nxt  = disp_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel   <= '0;
      seg_out     <= SEG_DARK;
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      digit_sel   <= sel_nxt;
      seg_out     <= seg_nxt;
      dp_out      <= dp_nxt;
      frame_start <= phase_done && (state_nxt == SHOW) && (idx_nxt == '0);
    end
  end

endmodule
